// File: rtl/reg_pipe.sv
// Elastic register pipeline with valid/ready handshake on both ends.
// Stalls ripple back combinationally, so empty stages fill even while the output is blocked.
module reg_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             out_ready,
    output logic [$clog2(STAGES+1)-1:0]      count
);

    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] free;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    // Entry 0 is the pipe input, entry i+1 is the output of stage i.
    logic [STAGES:0]   src_v;
    logic [WIDTH-1:0]  src_data [STAGES+1];

    // A stage is free if empty or if everything downstream of it can move.
    always_comb begin : free_chain
        logic f;
        f = !v_q[STAGES-1] || out_ready;
        free = '0;
        free[STAGES-1] = f;
        for (int i = STAGES - 2; i >= 0; i--) begin
            f = !v_q[i] || f;
            free[i] = f;
        end
    end

    always_comb begin
        src_v = {v_q, in_valid};
        src_data[0] = in_data;
        for (int i = 0; i < STAGES; i++) begin
            src_data[i+1] = data_q[i];
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        for (int i = 0; i < STAGES; i++) begin
            if (free[i]) begin
                v_d[i]    = src_v[i];
                data_d[i] = src_data[i];
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < STAGES; i++) begin
            count = count + CW'(v_q[i]);
        end
    end

    assign in_ready  = free[0] && !flush && reset_n;
    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe (WIDTH=4, STAGES=3): fill, stall, collapse, flush and reset scenarios.
module tb_reg_pipe;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic [1:0] count;

    int checks;
    int errors;

    reg_pipe #(.WIDTH(4), .STAGES(3)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 4'h7; out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        checks++;
        if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        reset_n = 1'b1; in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b expected 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [3:0] words [3];
        logic [3:0] exp_d [3];
        logic [1:0] exp_c [3];
        words = '{4'hA, 4'h5, 4'hF};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = words[i];
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 2'd3) begin errors++; $display("FAIL stream_count_peak: got %0d expected 3", count); end
        exp_d = '{4'hA, 4'h5, 4'hF};
        exp_c = '{2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || count !== exp_c[i]) begin
                errors++;
                $display("FAIL stream_out[%0d]: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d",
                         i, out_valid, out_data, count, exp_d[i], exp_c[i]);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL stream_drained: got v=%b c=%0d expected v=0 c=0", out_valid, count);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 4'(i);
            tick();
        end
        in_data = 4'h4;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready); end
        checks++;
        if (count !== 2'd3 || out_data !== 4'h1) begin
            errors++; $display("FAIL bp_full_state: got c=%0d d=%h expected c=3 d=1", count, out_data);
        end
        tick();
        checks++;
        if (count !== 2'd3 || out_data !== 4'h1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got c=%0d d=%h v=%b expected c=3 d=1 v=1", count, out_data, out_valid);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'(i)) begin
                errors++; $display("FAIL bp_order[%0d]: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 4'(i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_passthrough();
        logic [3:0] fill [3];
        fill = '{4'hD, 4'hE, 4'hB};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = fill[i];
            tick();
        end
        in_data = 4'h9; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 2'd3 || out_data !== 4'hE) begin
            errors++; $display("FAIL pass_same_edge: got c=%0d d=%h expected c=3 d=e", count, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data !== 4'hB || count !== 2'd2) begin
            errors++; $display("FAIL pass_next: got d=%h c=%0d expected d=b c=2", out_data, count);
        end
        tick();
        checks++;
        if (out_data !== 4'h9 || out_valid !== 1'b1) begin
            errors++; $display("FAIL pass_nine: got d=%h v=%b expected d=9 v=1", out_data, out_valid);
        end
        tick();
    endtask

    task automatic test_collapse();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h6;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h6 || count !== 2'd1) begin
            errors++; $display("FAIL collapse_six: got v=%b d=%h c=%0d expected v=1 d=6 c=1", out_valid, out_data, count);
        end
        in_valid = 1'b1; in_data = 4'h7;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (count !== 2'd2 || out_data !== 4'h6) begin
            errors++; $display("FAIL collapse_count: got c=%0d d=%h expected c=2 d=6", count, out_data);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h7) begin
            errors++; $display("FAIL collapse_seven: got v=%b d=%h expected v=1 d=7", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_flush();
        int seen_c;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'h2;
        tick();
        in_data = 4'h8;
        tick();
        checks++;
        if (count !== 2'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", count); end
        flush = 1'b1; in_data = 4'hC;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got c=%0d v=%b expected c=0 v=0", count, out_valid);
        end
        seen_c = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid === 1'b1) seen_c++;
        end
        checks++;
        if (seen_c !== 0) begin errors++; $display("FAIL flush_no_emit: got %0d valid cycles expected 0", seen_c); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 4'(4'h3 + i);
            tick();
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (count !== 2'd3 || out_valid !== 1'b1 || out_data !== 4'h3) begin
            errors++; $display("FAIL rst_no_edge: got c=%0d v=%b d=%h expected c=3 v=1 d=3", count, out_valid, out_data);
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            errors++; $display("FAIL rst_mid: got c=%0d v=%b d=%h expected c=0 v=0 d=0", count, out_valid, out_data);
        end
        reset_n = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            errors++; $display("FAIL rst_no_partial: got v=%b c=%0d expected v=0 c=0", out_valid, count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_full_passthrough();
        test_collapse();
        test_flush();
        test_reset_midstream();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
